// File: rtl/os_psum_collector.sv
// os_psum_collector: per-column OS-mode psum capture with per-row slots, lowest-row-first drain
// to valid/ready outputs, sticky overflow on slot collisions.
module os_psum_collector #(
    parameter int psum_bw = 16,
    parameter int col = 8,
    parameter int row = 8,
    localparam int RW = row > 1 ? $clog2(row) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_os_mode,
    input  logic                       i_flush,
    input  logic [row*col-1:0]         i_os_valid,
    input  logic [psum_bw*row*col-1:0] i_os_psum,
    input  logic [col-1:0]             i_out_ready,
    output logic [col-1:0]             o_out_valid,
    output logic [psum_bw*col-1:0]     o_out_data,
    output logic [RW*col-1:0]          o_out_row,
    output logic [col-1:0]             o_overflow,
    output logic                       o_busy
);
    logic [col-1:0] w_cbusy;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [row-1:0]              r_pend, w_drn;
        logic [row-1:0][psum_bw-1:0] r_slot;
        logic                        r_ovalid, r_ovf, w_free, w_any;
        logic [psum_bw-1:0]          r_odata;
        logic [RW-1:0]               r_orow, w_sel;

        assign w_free = !r_ovalid | i_out_ready[c];

        // Descending scan so the lowest pending row ends up selected.
        always_comb begin
            w_sel = '0;
            w_any = 1'b0;
            for (int r = row - 1; r >= 0; r--)
                if (r_pend[r]) begin
                    w_sel = RW'(r);
                    w_any = 1'b1;
                end
            w_drn = '0;
            if (w_free && w_any) w_drn[w_sel] = 1'b1;
        end

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_pend   <= '0;
                r_slot   <= '0;
                r_ovalid <= 1'b0;
                r_odata  <= '0;
                r_orow   <= '0;
                r_ovf    <= 1'b0;
            end else if (i_flush) begin
                r_pend   <= '0;
                r_ovalid <= 1'b0;
            end else begin
                if (w_free) begin
                    r_ovalid <= w_any;
                    if (w_any) begin
                        r_odata <= r_slot[w_sel];
                        r_orow  <= w_sel;
                    end
                end
                // A slot drained on this edge may be refilled on the same edge.
                for (int r = 0; r < row; r++) begin
                    if (i_os_mode && i_os_valid[r*col+c]) begin
                        if (!r_pend[r] || w_drn[r]) begin
                            r_slot[r] <= i_os_psum[(r*col+c)*psum_bw +: psum_bw];
                            r_pend[r] <= 1'b1;
                        end else r_ovf <= 1'b1;
                    end else if (w_drn[r]) r_pend[r] <= 1'b0;
                end
            end
        end

        assign o_out_valid[c]                   = r_ovalid;
        assign o_out_data[c*psum_bw +: psum_bw] = r_odata;
        assign o_out_row[c*RW +: RW]            = r_orow;
        assign o_overflow[c]                    = r_ovf;
        assign w_cbusy[c]                       = |r_pend | r_ovalid;
    end

    assign o_busy = |w_cbusy;
endmodule
